// File: rtl/des_core_dispatcher.sv
// des_core_dispatcher
// Initiator-side controller for a bank of des_block cores sharing one
// configuration. It resets the cores, launches them with a single start
// pulse, captures each core's counter on its first done, then sums the
// captured counters serially and presents the total plus the WAIT cycle count.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   cmd_start       one-cycle launch request (honoured in IDLE or DONE)
//   cmd_abort       one-cycle cancel request (wins over cmd_start)
//   core_restart    broadcast restart_block pulse to all cores
//   core_start      broadcast start pulse to all cores
//   core_done       per-core done (pulse or level)
//   core_counter    per-core counter, core i at [i*CW +: CW]
//   busy            high outside IDLE and DONE
//   result_valid    high in DONE
//   done_mask       sticky per-core finished flags
//   total_count     sum of captured counters
//   elapsed         saturating count of WAIT cycles
module des_core_dispatcher #(
  parameter int unsigned NUM_CORES = 6,
  parameter int unsigned CW        = 64,
  parameter int unsigned SW        = CW + 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_start,
  input  logic                    cmd_abort,
  output logic                    core_restart,
  output logic                    core_start,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*CW-1:0] core_counter,
  output logic                    busy,
  output logic                    result_valid,
  output logic [NUM_CORES-1:0]    done_mask,
  output logic [SW-1:0]           total_count,
  output logic [31:0]             elapsed
);

  localparam int unsigned KW = 3;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_LAUNCH,
    S_WAIT,
    S_ACCUM,
    S_DONE,
    S_ABORT
  } state_t;

  state_t            state;
  logic [KW-1:0]     k_q;
  logic [CW-1:0]     cap_q [NUM_CORES];
  logic [NUM_CORES-1:0] new_done_c;
  logic [NUM_CORES-1:0] mask_nxt_c;

  // Cores finishing this cycle for the first time, and the mask after them.
  always_comb begin
    new_done_c = core_done & ~done_mask;
    mask_nxt_c = done_mask | core_done;
  end

  // Controller: state, broadcast pulses, capture, accumulation and timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k_q          <= '0;
      core_restart <= 1'b0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      done_mask    <= '0;
      total_count  <= '0;
      elapsed      <= '0;
      for (int i = 0; i < NUM_CORES; i++) cap_q[i] <= '0;
    end else begin
      core_restart <= 1'b0;
      core_start   <= 1'b0;
      if (cmd_abort && state != S_IDLE) begin
        // Cancel: restart the cores for one cycle, then fall back to IDLE.
        state        <= S_ABORT;
        core_restart <= 1'b1;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        done_mask    <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (cmd_start) begin
              state        <= S_RESTART;
              core_restart <= 1'b1;
              busy         <= 1'b1;
              result_valid <= 1'b0;
              done_mask    <= '0;
              total_count  <= '0;
              elapsed      <= '0;
              for (int i = 0; i < NUM_CORES; i++) cap_q[i] <= '0;
            end
          end
          S_RESTART: begin
            state      <= S_LAUNCH;
            core_start <= 1'b1;
          end
          S_LAUNCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (elapsed != '1) elapsed <= elapsed + 32'd1;
            done_mask <= mask_nxt_c;
            // Only the first done of each core is captured.
            for (int i = 0; i < NUM_CORES; i++) begin
              if (new_done_c[i]) cap_q[i] <= core_counter[i*CW +: CW];
            end
            if (&mask_nxt_c) begin
              state <= S_ACCUM;
              k_q   <= '0;
            end
          end
          S_ACCUM: begin
            total_count <= total_count + SW'(cap_q[k_q]);
            if (k_q == K_LAST) begin
              state        <= S_DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
          S_ABORT: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_des_core_dispatcher.sv
// Scoreboard bench for des_core_dispatcher: a behavioural core bank model,
// a run-level reference (sum of counters, longest done delay, fixed latency)
// and a result monitor decoupled from stimulus.
module tb_des_core_dispatcher;
  localparam int N  = 6;
  localparam int CW = 64;
  localparam int SW = 67;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_start;
  logic              cmd_abort;
  logic              core_restart;
  logic              core_start;
  logic [N-1:0]      core_done;
  logic [N*CW-1:0]   core_counter;
  logic              busy;
  logic              result_valid;
  logic [N-1:0]      done_mask;
  logic [SW-1:0]     total_count;
  logic [31:0]       elapsed;

  always #5 clk = ~clk;

  des_core_dispatcher #(.NUM_CORES(N), .CW(CW), .SW(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .cmd_abort    (cmd_abort),
    .core_restart (core_restart),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_counter (core_counter),
    .busy         (busy),
    .result_valid (result_valid),
    .done_mask    (done_mask),
    .total_count  (total_count),
    .elapsed      (elapsed)
  );

  typedef struct {
    logic [SW-1:0] total;
    logic [31:0]   elap;
    logic [N-1:0]  mask;
    int            lat;
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int            cfg_delay [N];
  bit            cfg_pulse [N];
  logic [CW-1:0] cfg_cnt   [N];

  int cyc       = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  // Core bank model: done at cfg_delay cycles after start, counter changes afterwards,
  // pulse-mode cores re-pulse done later with a different counter.
  int  m_rel;
  bit  m_run = 1'b0;
  initial begin
    core_done    = '0;
    core_counter = '0;
  end
  always @(negedge clk) begin
    if (!rst_n || core_restart) begin
      m_run     = 1'b0;
      core_done = '0;
    end else if (core_start) begin
      m_run     = 1'b1;
      m_rel     = 0;
      start_cyc = cyc;
      core_done = '0;
      for (int i = 0; i < N; i++) core_counter[i*CW +: CW] = cfg_cnt[i];
    end else if (m_run) begin
      m_rel++;
      for (int i = 0; i < N; i++) begin
        if (m_rel == cfg_delay[i]) begin
          core_done[i] = 1'b1;
          core_counter[i*CW +: CW] = cfg_cnt[i];
        end else if (m_rel == cfg_delay[i] + 1) begin
          core_counter[i*CW +: CW] = {$urandom, $urandom};
          if (cfg_pulse[i]) core_done[i] = 1'b0;
        end else if (cfg_pulse[i] && m_rel == cfg_delay[i] + 3) begin
          core_done[i] = 1'b1;
        end else if (cfg_pulse[i] && m_rel == cfg_delay[i] + 4) begin
          core_done[i] = 1'b0;
        end
      end
    end
  end

  // Result monitor: compares each presented result with the oldest expectation.
  bit prv_rv = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prv_rv = 1'b0;
    end else begin
      if (result_valid && !prv_rv) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got total %0h with no run pending", total_count);
        end else begin
          mon_e = exp_q.pop_front();
          chk("total", total_count, mon_e.total);
          chk("elapsed", elapsed, mon_e.elap);
          chk("done_mask", done_mask, mon_e.mask);
          chk("latency", cyc - start_cyc, mon_e.lat);
          chk("busy_in_done", busy, 1'b0);
        end
      end
      prv_rv = result_valid;
    end
  end

  task automatic rand_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_delay[i] = $urandom_range(1, 40);
      cfg_pulse[i] = 1'($urandom_range(0, 1));
      cfg_cnt[i]   = {$urandom, $urandom};
    end
  endtask

  // One run from IDLE/DONE. abort_at / rst_k < 0 disable those events;
  // start_at > 0 pulses an extra cmd_start that must be ignored.
  task automatic run(input int abort_at, input bit abort_start, input int start_at, input int rst_k);
    int            d_max;
    logic [SW-1:0] sum;
    logic [N-1:0]  m;
    bit            expect_res;
    bit            got;
    exp_t          e;
    expect_res = (abort_at < 0) && (rst_k < 0);
    d_max = 0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (cfg_delay[i] > d_max) d_max = cfg_delay[i];
      sum += SW'(cfg_cnt[i]);
    end
    if (expect_res) begin
      e.total = sum;
      e.elap  = 32'(d_max);
      e.mask  = '1;
      e.lat   = d_max + N + 1;
      exp_q.push_back(e);
    end
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("restart_pulse", {core_restart, core_start, busy, result_valid}, 4'b1010);
    chk("restart_clear", {done_mask, elapsed, total_count}, '0);
    @(negedge clk);
    chk("launch_pulse", {core_restart, core_start}, 2'b01);
    got = 1'b0;
    for (int rel = 1; rel <= d_max + 20; rel++) begin
      @(negedge clk);
      cmd_start = (rel == start_at);
      if (rel == abort_at) begin
        m = '0;
        for (int i = 0; i < N; i++) if (cfg_delay[i] < rel) m[i] = 1'b1;
        chk("pre_abort_mask", done_mask, m);
        cmd_abort = 1'b1;
        cmd_start = abort_start;
        @(negedge clk);
        cmd_abort = 1'b0;
        cmd_start = 1'b0;
        chk("abort_pulse", {core_restart, core_start, busy, result_valid}, 4'b1010);
        chk("abort_mask", done_mask, '0);
        @(negedge clk);
        chk("abort_idle", {core_restart, core_start, busy, result_valid}, 4'b0000);
        @(negedge clk);
        chk("abort_stays_idle", {core_restart, core_start, busy}, 3'b000);
        return;
      end
      if (rst_k >= 0 && rel == d_max + 1 + rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {core_restart, core_start, busy, result_valid, done_mask, elapsed, total_count}, '0);
        cmd_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("post_rst_quiet", {core_restart, core_start, busy, result_valid}, 4'b0000);
        end
        return;
      end
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
    cmd_start = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL result_timeout: result_valid never rose, expected after %0d cycles", d_max + N + 1);
    end else begin
      @(negedge clk);
      chk("result_hold", {result_valid, total_count}, {1'b1, sum});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_delay[i] = 1;
      cfg_pulse[i] = 1'b0;
      cfg_cnt[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_state", {core_restart, core_start, busy, result_valid, done_mask, elapsed, total_count}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("abort_in_idle_ignored", {core_restart, busy}, 2'b00);
    @(negedge clk);

    // Nominal: held dones 20 cycles after start.
    for (int i = 0; i < N; i++) begin
      cfg_delay[i] = 20;
      cfg_pulse[i] = 1'b0;
      cfg_cnt[i]   = 64'(16 * (i + 1));
    end
    run(-1, 1'b0, -1, -1);

    // Back-to-back staggered pulses, all-ones counters, cmd_start during ACCUM.
    cfg_delay = '{5, 9, 9, 14, 30, 31};
    for (int i = 0; i < N; i++) begin
      cfg_pulse[i] = 1'b1;
      cfg_cnt[i]   = '1;
    end
    run(-1, 1'b0, 31 + 3, -1);

    // Abort during WAIT with three cores finished.
    cfg_delay = '{3, 3, 3, 50, 50, 50};
    for (int i = 0; i < N; i++) cfg_pulse[i] = 1'b0;
    run(10, 1'b0, -1, -1);
    rand_cfg();
    run(-1, 1'b0, -1, -1);

    // Start and abort together in WAIT.
    cfg_delay = '{3, 3, 3, 50, 50, 50};
    run(12, 1'b1, -1, -1);

    // cmd_start during WAIT is ignored.
    rand_cfg();
    run(-1, 1'b0, 5, -1);

    // Done already high on the first WAIT edge: elapsed = 1.
    for (int i = 0; i < N; i++) cfg_delay[i] = 1;
    run(-1, 1'b0, -1, -1);

    // Asynchronous reset at ACCUM index 3, then a clean run.
    rand_cfg();
    run(-1, 1'b0, -1, 3);
    rand_cfg();
    run(-1, 1'b0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      rand_cfg();
      run(-1, 1'b0, -1, -1);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
